// File: rtl/gate_tester.sv
// gate_tester: drives all four 2-input vectors into a gate under test and checks o against EXPECT
//   clk, rst_n : clock, synchronous active-low reset
//   start      : run request, honoured only in IDLE
//   i0, i1     : registered stimulus to the gate; o is its combinational response
//   busy, done : run in progress, one-cycle completion pulse
//   pass, err_cnt, fail_vec : results of the last run, held until the next accepted start
module gate_tester #(
  parameter logic [3:0] EXPECT = 4'b0111,
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       o,
  output logic       i0,
  output logic       i1,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_vec
);
  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;
  localparam logic [3:0] LAST = 4'(SETTLE - 1);
  state_t state, state_n;
  logic [1:0] idx, idx_n, vec_n;
  logic [3:0] cnt, cnt_n, fv_n;
  logic [2:0] err_n;
  logic pass_n, miss;
  assign miss = o != EXPECT[idx];
  assign busy = state == APPLY;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    idx_n = idx;
    cnt_n = cnt;
    vec_n = {i1, i0};
    err_n = err_cnt;
    fv_n = fail_vec;
    pass_n = pass;
    case (state)
      IDLE: if (start) begin
        state_n = APPLY;
        idx_n = 2'd0;
        cnt_n = 4'd0;
        vec_n = 2'd0;
        err_n = 3'd0;
        fv_n = 4'd0;
        pass_n = 1'b0;
      end
      APPLY: if (cnt == LAST) begin
        err_n = err_cnt + 3'(miss);
        fv_n = fail_vec | (4'(miss) << idx);
        cnt_n = 4'd0;
        // index 3 wraps to 0, which also returns the stimulus to 00 on completion
        idx_n = idx + 2'd1;
        vec_n = idx + 2'd1;
        if (idx == 2'd3) begin
          state_n = DONE;
          pass_n = err_n == 3'd0;
        end
      end else cnt_n = cnt + 4'd1;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= 2'd0;
      cnt <= 4'd0;
      {i1, i0} <= 2'd0;
      err_cnt <= 3'd0;
      fail_vec <= 4'd0;
      pass <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      cnt <= cnt_n;
      {i1, i0} <= vec_n;
      err_cnt <= err_n;
      fail_vec <= fv_n;
      pass <= pass_n;
    end
  end
endmodule
